// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t : FSM state encoding (IDLE=0, RUN=1, DONE=2); the unused
//             encoding 3 is treated as IDLE by the top level.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_add_dataflow.sv
// Single-bit full adder cell, pure combinational.
// Ports:
//   a, b      : operand bits
//   carry_in  : carry into this bit
//   sum       : a ^ b ^ carry_in
//   carry     : majority(a, b, carry_in)
module full_add_dataflow (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ carry_in;
    assign carry = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: sums two WIDTH-bit operands plus carry_in, one bit per
// clock, LSB first, using a single full_add_dataflow cell.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand handshake (a, b, carry_in)
//   out_valid / out_ready : result handshake (sum, carry_out)
//   sum                 : registered a+b+carry_in mod 2^WIDTH
//   carry_out           : registered carry out of bit WIDTH-1
// Latency: accept on edge E0 -> out_valid after edge E0+WIDTH.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_nxt;
    state_t           state_dec;

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_q;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_sh_nxt;

    full_add_dataflow u_fa (
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .carry_in (carry_q),
        .sum      (fa_sum),
        .carry    (fa_carry)
    );

    assign sum_sh_nxt = {fa_sum, sum_sh[WIDTH-1:1]};

    // Unused encoding behaves exactly like IDLE everywhere downstream.
    always_comb begin
        state_dec = IDLE;
        case (state_q)
            RUN:     state_dec = RUN;
            DONE:    state_dec = DONE;
            default: state_dec = IDLE;
        endcase
    end

    assign in_ready  = (state_dec == IDLE);
    assign out_valid = (state_dec == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_dec;
        case (state_dec)
            IDLE: if (in_valid)            state_nxt = RUN;
            RUN:  if (cnt_q == LAST_CNT)   state_nxt = DONE;
            DONE: if (out_ready)           state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry_q   <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state_dec)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= carry_in;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    sum_sh  <= sum_sh_nxt;
                    a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    carry_q <= fa_carry;
                    cnt_q   <= cnt_q + 1'b1;
                    // Output regs only change on the final bit, so no
                    // partial result is ever visible on sum/carry_out.
                    if (cnt_q == LAST_CNT) begin
                        sum       <= sum_sh_nxt;
                        carry_out <= fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: a WIDTH=8 instance for
// reset, latency, carry chain, backpressure and back-to-back cases, and a
// WIDTH=2 instance swept over all operand combinations.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // WIDTH=8 instance signals
    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       out_valid8;
    logic       out_ready8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8;

    // WIDTH=2 instance signals
    logic       in_valid2 = 1'b0;
    logic       in_ready2;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       cin2 = 1'b0;
    logic       out_valid2;
    logic       out_ready2 = 1'b0;
    logic [1:0] sum2;
    logic       cout2;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .carry_in  (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .carry_out (cout8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .carry_in  (cin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .carry_out (cout2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offer one operand set to the WIDTH=8 instance, measure latency, check
    // the result, then complete the output handshake.
    task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] exp_sum, input logic exp_co);
        int n;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready8), 32'd1);
        in_valid8 = 1'b1;
        a8 = av; b8 = bv; cin8 = cv;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_sum"}, 32'(sum8), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout8), 32'(exp_co));
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check({tag, "_release"}, {30'd0, out_valid8, in_ready8}, 32'b01);
    endtask

    logic [7:0] bb_a    [4] = '{8'h3C, 8'hC8, 8'h7F, 8'h80};
    logic [7:0] bb_b    [4] = '{8'h0F, 8'h64, 8'h01, 8'h80};
    logic       bb_c    [4] = '{1'b1,  1'b0,  1'b0,  1'b1};
    logic [8:0] bb_exp  [4] = '{9'h04C, 9'h12C, 9'h080, 9'h101};

    initial begin
        bit stale;
        bit pending;
        int idx;
        int oidx;
        int cyc;
        int last_acc;
        int n;
        logic [2:0] exp2;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready8", 32'(in_ready8), 32'd1);
        check("rst_in_ready2", 32'(in_ready2), 32'd1);

        // Reset mid-operation: abort at cycle 3 of RUN
        in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready8), 32'd1);
        stale = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid8) stale = 1'b1;
        end
        check("abort_no_stale", 32'(stale), 32'd0);

        // Basic add and carry chain
        run8("basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
        run8("chain1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run8("chain2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Backpressure: result held, new operands ignored until handshake
        @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", 32'(n), 32'd8);
        in_valid8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {22'd0, out_valid8, in_ready8, cout8, sum8}, {22'd0, 1'b1, 1'b0, 1'b0, 8'h46});
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check("bp_idle", 32'(in_ready8), 32'd1);
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_new_latency", 32'(n), 32'd8);
        check("bp_new_result", {23'd0, cout8, sum8}, 32'h004);
        out_ready8 = 1'b1;
        @(negedge clk);

        // Back-to-back with out_ready and in_valid held high
        idx = 0; oidx = 0; last_acc = -1;
        a8 = bb_a[0]; b8 = bb_b[0]; cin8 = bb_c[0];
        in_valid8 = 1'b1;
        cyc = 0;
        while (oidx < 4 && cyc < 200) begin
            pending = in_valid8 && in_ready8;
            @(negedge clk);
            cyc++;
            if (pending) begin
                if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd10);
                last_acc = cyc;
                idx++;
                if (idx < 4) begin
                    a8 = bb_a[idx]; b8 = bb_b[idx]; cin8 = bb_c[idx];
                end else begin
                    in_valid8 = 1'b0;
                end
            end
            if (out_valid8) begin
                check("b2b_result", {23'd0, cout8, sum8}, 32'(bb_exp[oidx]));
                oidx++;
            end
        end
        check("b2b_count", 32'(oidx), 32'd4);
        in_valid8 = 1'b0;
        out_ready8 = 1'b0;

        // Exhaustive WIDTH=2
        for (int v = 0; v < 32; v++) begin
            @(negedge clk);
            a2 = 2'(v >> 3); b2 = 2'(v >> 1); cin2 = v[0];
            exp2 = 3'(a2) + 3'(b2) + 3'(cin2);
            in_valid2 = 1'b1;
            @(negedge clk);
            in_valid2 = 1'b0;
            n = 0;
            while (!out_valid2 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("w2_result", {29'd0, out_valid2, cout2, sum2}, {29'd0, 1'b1, exp2});
            out_ready2 = 1'b1;
            @(negedge clk);
            out_ready2 = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
